// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU sequencer and its decoder.
// Build option: ALU_CTRL_ILLEGAL_TRAP_EN is consumed by alu_ctrl.
package definitions;

  typedef enum logic [2:0] {
    ALU_O_ADD = 3'd0,
    ALU_O_SUB = 3'd1,
    ALU_O_AND = 3'd2,
    ALU_O_OR  = 3'd3,
    ALU_O_XOR = 3'd4
  } alu_operation;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } ctrl_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to ALU control bits.
// Illegal encodings default to ADD with every side effect disabled.
module alu_decode
  import definitions::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output alu_operation o_op,
  output logic         o_src_imm,
  output logic         o_wb_en,
  output logic         o_wb_sel_rt,
  output logic         o_is_branch,
  output logic         o_illegal
);

  logic w_rtype;
  logic w_addi;
  logic w_beq;

  assign w_rtype = (i_opcode == OPC_RTYPE);
  assign w_addi  = (i_opcode == OPC_ADDI);
  assign w_beq   = (i_opcode == OPC_BEQ);

  always_comb begin
    o_op        = ALU_O_ADD;
    o_src_imm   = 1'b0;
    o_wb_en     = 1'b0;
    o_wb_sel_rt = 1'b0;
    o_is_branch = 1'b0;
    o_illegal   = 1'b1;
    unique case (1'b1)
      w_rtype: begin
        o_wb_en   = 1'b1;
        o_illegal = 1'b0;
        case (i_funct)
          FN_ADD:  o_op = ALU_O_ADD;
          FN_SUB:  o_op = ALU_O_SUB;
          FN_AND:  o_op = ALU_O_AND;
          FN_OR:   o_op = ALU_O_OR;
          FN_XOR:  o_op = ALU_O_XOR;
          default: begin
            o_wb_en   = 1'b0;
            o_illegal = 1'b1;
          end
        endcase
      end
      w_addi: begin
        o_op        = ALU_O_ADD;
        o_src_imm   = 1'b1;
        o_wb_en     = 1'b1;
        o_wb_sel_rt = 1'b1;
        o_illegal   = 1'b0;
      end
      w_beq: begin
        o_op        = ALU_O_SUB;
        o_is_branch = 1'b1;
        o_illegal   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Four-state sequencer: IDLE -> DECODE -> EXEC -> WB around the ALU.
// ALU_CTRL_ILLEGAL_TRAP_EN: illegal instructions halt until reset.
module alu_ctrl
  import definitions::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  instr_i,
  input  logic         instr_valid_i,
  output logic         instr_ready_o,
  output logic [4:0]   rs_addr_o,
  output logic [4:0]   rt_addr_o,
  output alu_operation op_o,
  output logic         alu_src_imm_o,
  output logic [31:0]  imm_o,
  input  logic [31:0]  alu_result_i,
  input  logic         alu_zero_i,
  output logic [4:0]   rd_addr_o,
  output logic         rd_we_o,
  output logic [31:0]  wb_data_o,
  output logic         branch_taken_o,
  output logic [31:0]  branch_offset_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         illegal_o
);

  ctrl_state_t  r_state;
  ctrl_state_t  w_next;
  logic         w_accept;

  alu_operation w_op;
  logic         w_src_imm;
  logic         w_wb_en;
  logic         w_wb_sel_rt;
  logic         w_is_branch;
  logic         w_ill;

  alu_operation r_op_dec;
  logic         r_wb_en;
  logic         r_is_branch;
  logic         r_ready;
  logic [4:0]   r_rs;
  logic [4:0]   r_rt;
  logic [4:0]   r_rd;
  logic [31:0]  r_imm;
  logic         r_src_imm;
  logic [31:0]  r_boff;
  alu_operation r_op;
  logic [31:0]  r_wb_data;
  logic         r_we;
  logic         r_done;
  logic         r_taken;

  alu_decode u_dec (
    .i_opcode    (instr_i[31:26]),
    .i_funct     (instr_i[5:0]),
    .o_op        (w_op),
    .o_src_imm   (w_src_imm),
    .o_wb_en     (w_wb_en),
    .o_wb_sel_rt (w_wb_sel_rt),
    .o_is_branch (w_is_branch),
    .o_illegal   (w_ill)
  );

  assign w_accept = instr_valid_i && r_ready;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic r_ill;
  logic r_illegal;
  logic w_unused;

  assign w_unused  = ^instr_i[10:6];
  assign illegal_o = r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ill     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) r_ill <= w_ill;
      if (r_state == EXEC && r_ill) r_illegal <= 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^{instr_i[10:6], w_ill};
  assign illegal_o = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next = DECODE;
      DECODE: w_next = EXEC;
      EXEC:   w_next = WB;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      WB:     w_next = r_ill ? HALT : IDLE;
      HALT:   w_next = HALT;
`else
      WB:     w_next = IDLE;
      HALT:   w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
    end
  end

  // Decode results are captured at acceptance; instr_i is ignored after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_dec    <= ALU_O_ADD;
      r_wb_en     <= 1'b0;
      r_is_branch <= 1'b0;
      r_rs        <= 5'd0;
      r_rt        <= 5'd0;
      r_rd        <= 5'd0;
      r_imm       <= 32'd0;
      r_src_imm   <= 1'b0;
      r_boff      <= 32'd0;
    end else if (w_accept) begin
      r_op_dec    <= w_op;
      r_wb_en     <= w_wb_en;
      r_is_branch <= w_is_branch;
      r_rs        <= instr_i[25:21];
      r_rt        <= instr_i[20:16];
      r_rd        <= w_wb_sel_rt ? instr_i[20:16]
                                 : instr_i[15:11];
      r_imm       <= sext16(instr_i[15:0]);
      r_src_imm   <= w_src_imm;
      r_boff      <= {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= ALU_O_ADD;
      r_wb_data <= 32'd0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_taken   <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_taken <= 1'b0;
      if (r_state == DECODE) r_op <= r_op_dec;
      if (r_state == EXEC) begin
        r_wb_data <= alu_result_i;
        r_taken   <= r_is_branch && alu_zero_i;
        r_we      <= r_wb_en && (r_rd != 5'd0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        r_done    <= !r_ill;
`else
        r_done    <= 1'b1;
`endif
      end
    end
  end

  assign instr_ready_o   = r_ready;
  assign busy_o          = (r_state != IDLE);
  assign rs_addr_o       = r_rs;
  assign rt_addr_o       = r_rt;
  assign rd_addr_o       = r_rd;
  assign imm_o           = r_imm;
  assign alu_src_imm_o   = r_src_imm;
  assign branch_offset_o = r_boff;
  assign op_o            = r_op;
  assign wb_data_o       = r_wb_data;
  assign rd_we_o         = r_we;
  assign done_o          = r_done;
  assign branch_taken_o  = r_taken;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: expected retire data queued at issue.
// Honours ALU_CTRL_ILLEGAL_TRAP_EN for the illegal-instruction case.
module tb_alu_ctrl;
  import definitions::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  instr_i = 32'd0;
  logic         instr_valid_i = 1'b0;
  logic         instr_ready_o;
  logic [4:0]   rs_addr_o, rt_addr_o, rd_addr_o;
  alu_operation op_o;
  logic         alu_src_imm_o;
  logic [31:0]  imm_o;
  logic [31:0]  alu_result_i = 32'd0;
  logic         alu_zero_i = 1'b0;
  logic         rd_we_o;
  logic [31:0]  wb_data_o;
  logic         branch_taken_o;
  logic [31:0]  branch_offset_o;
  logic         done_o, busy_o, illegal_o;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]   rs, rt, rd;
    logic [31:0]  imm, wb, boff;
    logic         src, we, taken, done, ill, illo, halt;
    alu_operation op;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .reset(reset),
    .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o),
    .op_o(op_o), .alu_src_imm_o(alu_src_imm_o), .imm_o(imm_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .wb_data_o(wb_data_o),
    .branch_taken_o(branch_taken_o),
    .branch_offset_o(branch_offset_o),
    .done_o(done_o), .busy_o(busy_o), .illegal_o(illegal_o)
  );

  function automatic exp_t model(input logic [31:0] ins,
                                 input logic [31:0] res,
                                 input logic z);
    exp_t e;
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
    e.imm = 32'($signed(ins[15:0]));
    e.boff = e.imm * 4;
    e.wb = res; e.src = 0; e.taken = 0; e.done = 1;
    e.ill = 0; e.halt = 0; e.op = ALU_O_ADD;
    case (ins[31:26])
      6'd0: case (ins[5:0])
        6'h20: e.op = ALU_O_ADD;
        6'h22: e.op = ALU_O_SUB;
        6'h24: e.op = ALU_O_AND;
        6'h25: e.op = ALU_O_OR;
        6'h26: e.op = ALU_O_XOR;
        default: e.ill = 1;
      endcase
      6'd8: begin e.src = 1; e.rd = ins[20:16]; end
      6'd4: begin e.op = ALU_O_SUB; e.taken = z; end
      default: e.ill = 1;
    endcase
    e.we = !e.ill && ins[31:26] != 6'd4 && e.rd != 0;
    e.illo = 0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    if (e.ill) begin e.done = 0; e.halt = 1; e.illo = 1; end
`endif
    return e;
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] res,
                       input logic z, input string nm);
    exp_t e;
    int k = 0;
    while (!instr_ready_o && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_timeout got %b exp 1", nm, instr_ready_o);
    end
    instr_i = ins; instr_valid_i = 1; alu_result_i = res; alu_zero_i = z;
    sb.push_back(model(ins, res, z));
    @(posedge clk); #1;
    instr_valid_i = 0; instr_i = ~ins;
    @(negedge clk);
    e = sb[0];
    n_checks++; if (rs_addr_o !== e.rs) begin n_fail++; $display("FAIL %s rs got %h exp %h", nm, rs_addr_o, e.rs); end
    n_checks++; if (rt_addr_o !== e.rt) begin n_fail++; $display("FAIL %s rt got %h exp %h", nm, rt_addr_o, e.rt); end
    n_checks++; if (imm_o !== e.imm) begin n_fail++; $display("FAIL %s imm got %h exp %h", nm, imm_o, e.imm); end
    n_checks++; if (alu_src_imm_o !== e.src) begin n_fail++; $display("FAIL %s src_imm got %b exp %b", nm, alu_src_imm_o, e.src); end
    n_checks++; if (busy_o !== 1'b1 || instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL %s c1_busy_ready got %b%b exp 10", nm, busy_o, instr_ready_o); end
    @(negedge clk);
    if (!e.ill) begin
      n_checks++; if (op_o !== e.op) begin n_fail++; $display("FAIL %s op_exec got %0d exp %0d", nm, op_o, e.op); end
    end
    n_checks++; if (done_o !== 1'b0 || rd_we_o !== 1'b0) begin n_fail++; $display("FAIL %s c2_done_we got %b%b exp 00", nm, done_o, rd_we_o); end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if (done_o !== e.done) begin n_fail++; $display("FAIL %s done got %b exp %b", nm, done_o, e.done); end
    n_checks++; if (rd_we_o !== e.we) begin n_fail++; $display("FAIL %s we got %b exp %b", nm, rd_we_o, e.we); end
    n_checks++; if (wb_data_o !== e.wb) begin n_fail++; $display("FAIL %s wb_data got %h exp %h", nm, wb_data_o, e.wb); end
    n_checks++; if (branch_taken_o !== e.taken) begin n_fail++; $display("FAIL %s taken got %b exp %b", nm, branch_taken_o, e.taken); end
    n_checks++; if (branch_offset_o !== e.boff) begin n_fail++; $display("FAIL %s boff got %h exp %h", nm, branch_offset_o, e.boff); end
    n_checks++; if (illegal_o !== e.illo) begin n_fail++; $display("FAIL %s illegal got %b exp %b", nm, illegal_o, e.illo); end
    if (!e.ill) begin
      n_checks++; if (rd_addr_o !== e.rd) begin n_fail++; $display("FAIL %s rd got %h exp %h", nm, rd_addr_o, e.rd); end
      n_checks++; if (op_o !== e.op) begin n_fail++; $display("FAIL %s op_wb got %0d exp %0d", nm, op_o, e.op); end
    end
    @(negedge clk);
    n_checks++; if (instr_ready_o !== !e.halt) begin n_fail++; $display("FAIL %s c4_ready got %b exp %b", nm, instr_ready_o, !e.halt); end
    n_checks++; if (done_o !== 1'b0 || rd_we_o !== 1'b0) begin n_fail++; $display("FAIL %s c4_pulse got %b%b exp 00", nm, done_o, rd_we_o); end
  endtask

  task automatic test_reset();
    #1 reset = 1;
    #1;
    n_checks++;
    if ({instr_ready_o, rs_addr_o, rt_addr_o, alu_src_imm_o, imm_o, rd_addr_o, rd_we_o,
         wb_data_o, branch_taken_o, branch_offset_o, done_o, busy_o, illegal_o} !== '0) begin
      n_fail++; $display("FAIL reset outputs_nonzero got ready=%b busy=%b we=%b", instr_ready_o, busy_o, rd_we_o);
    end
    n_checks++; if (op_o !== ALU_O_ADD) begin n_fail++; $display("FAIL reset op got %0d exp %0d", op_o, ALU_O_ADD); end
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_checks++; if (instr_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset idle got ready=%b busy=%b exp 1 0", instr_ready_o, busy_o); end
  endtask

  task automatic test_add();
    issue(32'h00221820, 32'h0000_0007, 1'b0, "add");
  endtask

  task automatic test_addi();
    issue(32'h2005FFFC, 32'hFFFF_FFFC, 1'b0, "addi");
  endtask

  task automatic test_beq();
    issue(32'h10220003, 32'h0, 1'b1, "beq_taken");
    issue(32'h10220003, 32'h5, 1'b0, "beq_not");
    issue(32'h1022FFFF, 32'h0, 1'b1, "beq_neg");
  endtask

  task automatic test_or_r0();
    issue(32'h00220025, 32'h0000_0003, 1'b0, "or_r0");
  endtask

  task automatic test_random();
    logic [5:0] fn [5];
    fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25; fn[4] = 6'h26;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if (i % 4 == 3) ins[31:26] = 6'h08;
      else begin ins[31:26] = 6'h00; ins[5:0] = fn[$urandom_range(0, 4)]; end
      issue(ins, $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int k = 0, t0 = -1, t1 = -1;
    logic ld_b = 0, drop = 0;
    while (!instr_ready_o && k < 20) begin @(negedge clk); k++; end
    k = 0;
    instr_i = 32'h00221820; instr_valid_i = 1;
    alu_result_i = 32'h11; alu_zero_i = 0;
    sb.push_back(model(32'h00221820, 32'h11, 0));
    while (k < 40 && (t1 < 0 || sb.size() > 0)) begin
      if (ld_b) begin
        ld_b = 0; instr_i = 32'h00853022;
        sb.push_back(model(32'h00853022, 32'h22, 0));
      end
      if (drop) begin drop = 0; instr_valid_i = 0; end
      if (done_o) begin
        e = sb.pop_front();
        alu_result_i = 32'h22;
        n_checks++; if (wb_data_o !== e.wb || rd_we_o !== e.we || rd_addr_o !== e.rd) begin
          n_fail++; $display("FAIL b2b retire got %h/%b/%h exp %h/%b/%h", wb_data_o, rd_we_o, rd_addr_o, e.wb, e.we, e.rd);
        end
      end
      if (instr_valid_i && instr_ready_o) begin
        if (t0 < 0) begin t0 = k; ld_b = 1; end
        else if (t1 < 0) begin t1 = k; drop = 1; end
      end
      @(negedge clk);
      k++;
    end
    n_checks++; if (t0 < 0 || t1 - t0 != 4) begin n_fail++; $display("FAIL b2b spacing got %0d exp 4", t1 - t0); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b drain got %0d exp 0", sb.size()); sb.delete(); end
    instr_valid_i = 0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic seen = 0;
    while (!instr_ready_o && k < 20) begin @(negedge clk); k++; end
    instr_i = 32'h00221820; instr_valid_i = 1; alu_result_i = 32'h9;
    @(posedge clk); #1 instr_valid_i = 0;
    @(negedge clk); @(negedge clk);
    reset = 1;
    #1;
    n_checks++;
    if ({instr_ready_o, rs_addr_o, rt_addr_o, imm_o, rd_addr_o, rd_we_o, wb_data_o,
         done_o, busy_o, branch_offset_o} !== '0 || op_o !== ALU_O_ADD) begin
      n_fail++; $display("FAIL rst_exec outputs got busy=%b rs=%h op=%0d exp 0 0 0", busy_o, rs_addr_o, op_o);
    end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_we_o || done_o) seen = 1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_exec dropped got 1 exp 0"); end
    n_checks++; if (instr_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_exec idle got %b%b exp 10", instr_ready_o, busy_o); end
  endtask

  task automatic test_illegal();
    issue(32'hFC000000, 32'h0000_00AB, 1'b0, "illegal_opc");
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    repeat (6) @(negedge clk);
    n_checks++; if (instr_ready_o !== 1'b0 || busy_o !== 1'b1 || illegal_o !== 1'b1) begin
      n_fail++; $display("FAIL halt stuck got %b%b%b exp 011", instr_ready_o, busy_o, illegal_o);
    end
    reset = 1; @(negedge clk); reset = 0; @(negedge clk);
    n_checks++; if (instr_ready_o !== 1'b1 || illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL halt clear got %b%b exp 10", instr_ready_o, illegal_o);
    end
`else
    issue(32'h0022182A, 32'h0000_0001, 1'b0, "illegal_fn");
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_beq();
    test_or_r0();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
